// File: rtl/lal_pkg.sv
// Shared types and constants for the count sequencer slice.
// Contents: FSM state encoding, default counter/code widths, stall saturation value.
// No logic; imported by the sequencer top and its interface.
package lal_pkg;

    localparam int CW_DEF = 9;
    localparam int KW_DEF = 4;

    // Saturation value of the stall counter at the default counter width.
    localparam logic [CW_DEF-1:0] STALL_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/lal_count_sequencer_if.sv
// Command/response bundle between a command source and lal_count_sequencer.
// Ports: req_* command channel (valid/ready), hold/clr controls, cnt_out/busy status,
//        rsp_* response channel (valid/ready) carrying ge/eq/stalls.
interface lal_count_sequencer_if #(
    parameter int CW = lal_pkg::CW_DEF,
    parameter int KW = lal_pkg::KW_DEF
);
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_count;
    logic [KW-1:0] req_code;
    logic [KW-1:0] req_thresh;
    logic          hold;
    logic          clr;
    logic [CW-1:0] cnt_out;
    logic          busy;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_ge;
    logic          rsp_eq;
    logic [CW-1:0] rsp_stalls;

    // Command source side.
    modport master (
        output req_valid, req_count, req_code, req_thresh, hold, clr, rsp_ready,
        input  req_ready, cnt_out, busy, rsp_valid, rsp_ge, rsp_eq, rsp_stalls
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_count, req_code, req_thresh, hold, clr, rsp_ready,
        output req_ready, cnt_out, busy, rsp_valid, rsp_ge, rsp_eq, rsp_stalls
    );
endinterface

// File: rtl/lal_mag_cmp.sv
// Unsigned magnitude comparator: ge = (a >= b), eq = (a == b).
// Ports: a, b (KW bits) in; ge, eq out. Purely combinational, zero latency.
// No flow control; usable on either side of the count/compare datapath.
module lal_mag_cmp #(
    parameter int KW = 4
) (
    input  logic [KW-1:0] a,
    input  logic [KW-1:0] b,
    output logic          ge,
    output logic          eq
);
    assign ge = (a >= b);
    assign eq = (a == b);
endmodule

// File: rtl/lal_count_sequencer.sv
// Accepts a count job, counts it down to zero (stalling on hold), returns code/threshold compare + stall count.
// Ports: pclk/prst plain; bus (slave modport) carries command, controls, status and response.
// Latency N+1 cycles from acceptance to rsp_valid plus one per hold cycle; response held until rsp_ready.
module lal_count_sequencer
    import lal_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int KW = KW_DEF
) (
    input  logic                  pclk,
    input  logic                  prst,
    lal_count_sequencer_if.slave  bus
);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] stalls;
    logic          ge_q;
    logic          eq_q;
    logic          cmp_ge;
    logic          cmp_eq;

    lal_mag_cmp #(.KW(KW)) u_cmp (
        .a  (bus.req_code),
        .b  (bus.req_thresh),
        .ge (cmp_ge),
        .eq (cmp_eq)
    );

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.clr) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (bus.req_valid)                 state_nxt = ST_RUN;
                ST_RUN:  if (!bus.hold && cnt == '0)        state_nxt = ST_DONE;
                ST_DONE: if (bus.rsp_ready)                 state_nxt = ST_IDLE;
                default:                                    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Counter, stall count and compare results. Values survive the response
    // handshake so the last job's result stays observable in IDLE.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            cnt    <= '0;
            stalls <= '0;
            ge_q   <= 1'b0;
            eq_q   <= 1'b0;
        end else if (bus.clr) begin
            cnt    <= '0;
            stalls <= '0;
            ge_q   <= 1'b0;
            eq_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        cnt    <= bus.req_count;
                        stalls <= '0;
                        ge_q   <= cmp_ge;
                        eq_q   <= cmp_eq;
                    end
                end
                ST_RUN: begin
                    if (bus.hold) begin
                        // Saturate rather than wrap once all ones.
                        if (!(&stalls)) stalls <= stalls + CW'(1);
                    end else if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake/status outputs decode the state register only.
    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.rsp_valid  = (state == ST_DONE);
    assign bus.cnt_out    = cnt;
    assign bus.rsp_stalls = stalls;
    assign bus.rsp_ge     = ge_q;
    assign bus.rsp_eq     = eq_q;

endmodule
